// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//
// Load/store initiator between the execute stage and the data memory.
// Accepts one byte-addressed RV64 load or store per handshake and drives the
// entry-indexed memory port. Each memory entry is one 64-bit doubleword.
// Sub-doubleword stores are done as read-modify-write so that the other bytes
// of the entry are preserved. Loads return the addressed lane,
// sign- or zero-extended.
//
// Optional feature macro: MAU_ALIGN_CHECK_EN
//   defined   : misaligned requests get an error response and no memory access.
//   undefined : no error is ever raised. The low size bits of the byte offset
//               are cleared, which forces the access to be aligned.
//
// Ports:
//   clk            in   single clock, rising edge
//   rst            in   asynchronous active-low reset
//   req_valid      in   request present
//   req_ready      out  unit can accept (IDLE only)
//   req_we         in   1 = store, 0 = load
//   req_funct3     in   [1:0] size (B/H/W/D), [2] unsigned load
//   req_addr       in   64-bit byte address
//   req_wdata      in   store data, right-aligned
//   resp_valid     out  one-cycle response pulse
//   resp_rdata     out  extended load data (0 for stores and errors)
//   resp_err       out  misaligned request, valid with resp_valid
//   mem_addr       out  entry index = req_addr[DATA_MEM_WIDTH+2:3]
//   mem_data_width out  always 3 (full entry)
//   mem_we/mem_re  out  memory write / read enables
//   mem_data_out   out  merged write entry
//   mem_data_in    in   combinational read data from memory
// ---------------------------------------------------------------------------
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef DATA_MEM_WIDTH
`define DATA_MEM_WIDTH 8
`endif

module mem_access_unit (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_we,
  input  logic [2:0]                 req_funct3,
  input  logic [63:0]                req_addr,
  input  logic [`DATA_WIDTH-1:0]     req_wdata,
  output logic                       resp_valid,
  output logic [`DATA_WIDTH-1:0]     resp_rdata,
  output logic                       resp_err,
  output logic [`DATA_MEM_WIDTH-1:0] mem_addr,
  output logic [2:0]                 mem_data_width,
  output logic                       mem_we,
  output logic                       mem_re,
  output logic [`DATA_WIDTH-1:0]     mem_data_out,
  input  logic [`DATA_WIDTH-1:0]     mem_data_in
);

  localparam int DW = `DATA_WIDTH;
  localparam int MW = `DATA_MEM_WIDTH;
  localparam int NB = DW / 8;

  typedef enum logic [2:0] {IDLE, LOAD, ST_RD, ST_WR, RESP} state_e;

  state_e          state_q;
  logic [MW-1:0]   mem_addr_q;
  logic [2:0]      off_q;
  logic [1:0]      size_q;
  logic            uns_q;
  logic [DW-1:0]   wdata_q;
  logic [DW-1:0]   rdata_q;
  logic            err_q;
  logic            resp_valid_q;
  logic            mem_re_q;
  logic            mem_we_q;
  logic [DW-1:0]   mem_data_out_q;

  logic [2:0]      acc_mask;
  logic [2:0]      acc_off;
  logic            acc_misaligned;
  logic [DW-1:0]   lane;
  logic [DW-1:0]   load_data;
  logic [NB-1:0]   byte_en;
  logic [DW-1:0]   bit_mask;
  logic [DW-1:0]   wdata_shifted;
  logic [DW-1:0]   merged;

  // Address bits above the entry index are ignored, so the index wraps.
  logic            unused_addr_hi;
  assign unused_addr_hi = ^req_addr[63:MW+3];

  // acc_mask holds the low address bits that must be zero for the requested size.
  always_comb begin
    acc_mask = 3'b111;
    case (req_funct3[1:0])
      2'd0:    acc_mask = 3'b000;
      2'd1:    acc_mask = 3'b001;
      2'd2:    acc_mask = 3'b011;
      default: acc_mask = 3'b111;
    endcase
  end

`ifdef MAU_ALIGN_CHECK_EN
  assign acc_misaligned = |(req_addr[2:0] & acc_mask);
  assign acc_off        = req_addr[2:0];
`else
  assign acc_misaligned = 1'b0;
  assign acc_off        = req_addr[2:0] & ~acc_mask;
`endif

  // Load path: shift the addressed lane down to bit 0, then extend it to full width.
  // For a doubleword the unsigned bit has no effect, so 3'b111 behaves as LD.
  always_comb begin
    lane      = mem_data_in >> {off_q, 3'b000};
    load_data = lane;
    case (size_q)
      2'd0:    load_data = {{(DW-8){lane[7] & ~uns_q}}, lane[7:0]};
      2'd1:    load_data = {{(DW-16){lane[15] & ~uns_q}}, lane[15:0]};
      2'd2:    load_data = {{(DW-32){lane[31] & ~uns_q}}, lane[31:0]};
      default: load_data = lane;
    endcase
  end

  // Store path: replace bytes [off .. off+size-1] of the entry that was read.
  // The offset is always aligned at this point, so the byte enables never wrap.
  always_comb begin
    byte_en = '0;
    case (size_q)
      2'd0:    byte_en = NB'(8'h01);
      2'd1:    byte_en = NB'(8'h03);
      2'd2:    byte_en = NB'(8'h0F);
      default: byte_en = NB'(8'hFF);
    endcase
    byte_en  = byte_en << off_q;
    bit_mask = '0;
    for (int b = 0; b < NB; b++) begin
      bit_mask[b*8 +: 8] = {8{byte_en[b]}};
    end
    wdata_shifted = wdata_q << {off_q, 3'b000};
    merged        = (mem_data_in & ~bit_mask) | (wdata_shifted & bit_mask);
  end

  // Memory enables are set one state early, so they are already high in
  // LOAD / ST_RD / ST_WR and return low on the edge that leaves those states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      mem_addr_q     <= '0;
      off_q          <= '0;
      size_q         <= '0;
      uns_q          <= 1'b0;
      wdata_q        <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      resp_valid_q   <= 1'b0;
      mem_re_q       <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_data_out_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            mem_addr_q <= req_addr[MW+2:3];
            off_q      <= acc_off;
            size_q     <= req_funct3[1:0];
            uns_q      <= req_funct3[2];
            wdata_q    <= req_wdata;
            rdata_q    <= '0;
            err_q      <= acc_misaligned;
            if (acc_misaligned) begin
              resp_valid_q <= 1'b1;
              state_q      <= RESP;
            end else begin
              mem_re_q <= 1'b1;
              state_q  <= req_we ? ST_RD : LOAD;
            end
          end
        end
        LOAD: begin
          rdata_q      <= load_data;
          mem_re_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        ST_RD: begin
          // The merge is registered directly into the write-data register.
          mem_data_out_q <= merged;
          mem_re_q       <= 1'b0;
          mem_we_q       <= 1'b1;
          state_q        <= ST_WR;
        end
        ST_WR: begin
          mem_we_q     <= 1'b0;
          resp_valid_q <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          state_q      <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready      = (state_q == IDLE);
  assign resp_valid     = resp_valid_q;
  assign resp_rdata     = rdata_q;
  assign resp_err       = err_q;
  assign mem_addr       = mem_addr_q;
  assign mem_data_width = 3'd3;
  assign mem_we         = mem_we_q;
  assign mem_re         = mem_re_q;
  assign mem_data_out   = mem_data_out_q;

endmodule
